// File: rtl/serial_link_chan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_link_chan_pkg
//  Purpose  : Shared definitions for the serial-link AXI channel packer.
//             AXI channel payload widths derived from the address, data, id
//             and user widths. Also holds the default per-channel width table,
//             the packer FSM state type and a flit-count helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_link_chan_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ID_WIDTH   = 1;
    localparam int unsigned USER_WIDTH = 1;

    // Flattened channel payload sizes.
    localparam int unsigned AW_CHAN_BITS = 35 + ADDR_WIDTH + ID_WIDTH + USER_WIDTH;
    localparam int unsigned W_CHAN_BITS  = 1 + DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH;
    localparam int unsigned B_CHAN_BITS  = 2 + ID_WIDTH + USER_WIDTH;
    localparam int unsigned AR_CHAN_BITS = 29 + ADDR_WIDTH + ID_WIDTH + USER_WIDTH;
    localparam int unsigned R_CHAN_BITS  = 3 + DATA_WIDTH + ID_WIDTH + USER_WIDTH;

    // Default channel set is AW, W, AR (index 0, 1, 2).
    localparam int unsigned NUM_CHAN_DEFAULT = 3;
    localparam int unsigned DEFAULT_CHAN_BITS [NUM_CHAN_DEFAULT] =
        '{AW_CHAN_BITS, W_CHAN_BITS, AR_CHAN_BITS};

    localparam int unsigned CHAN_ID_WIDTH_DEFAULT = $clog2(NUM_CHAN_DEFAULT);

    typedef logic [CHAN_ID_WIDTH_DEFAULT-1:0] chan_id_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pack_state_e;

    // Number of flits needed to carry 'bits' payload bits.
    function automatic int unsigned num_flits(input int unsigned bits,
                                              input int unsigned flitw);
        return (bits + flitw - 1) / flitw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_link_axi_chan_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_link_axi_chan_packer_if
//  Purpose  : Payload input streams and flit output stream of the packer.
//  Signals  : in_valid_i/in_ready_o/in_data_i - per-channel payload handshake
//             out_valid_o/out_ready_i         - flit handshake
//             out_data_o/out_chan_o/out_last_o - flit payload, id, last flag
//  Modports : master - payload source / flit sink side
//             slave  - the packer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_link_axi_chan_packer_if #(
    parameter int unsigned NumChan       = 3,
    parameter int unsigned FlitDataWidth = 16,
    parameter int unsigned MaxChanBits   = 69,
    parameter int unsigned ChanIdW       = (NumChan > 1) ? $clog2(NumChan) : 1
);
    logic [NumChan-1:0]                  in_valid_i;
    logic [NumChan-1:0]                  in_ready_o;
    logic [NumChan-1:0][MaxChanBits-1:0] in_data_i;
    logic                                out_valid_o;
    logic                                out_ready_i;
    logic [FlitDataWidth-1:0]            out_data_o;
    logic [ChanIdW-1:0]                  out_chan_o;
    logic                                out_last_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_chan_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_chan_o, out_last_o
    );
endinterface
`default_nettype wire

// File: rtl/serial_link_credit_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : serial_link_credit_cnt
//  Purpose  : Per-channel credit counter. Reloads to MaxCredits on reset,
//             decrements on a grant, increments on a credit return, and
//             holds when both happen together. A return while already full
//             is dropped and sets a sticky overflow flag.
//  Ports    : clk_i, rst_i - clock, synchronous active-high reset
//             dec_i        - credit consumed (grant)
//             inc_i        - credit returned
//             cnt_o        - current credit count
//             ovf_o        - sticky overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module serial_link_credit_cnt #(
    parameter int unsigned MaxCredits = 4,
    parameter int unsigned CntW       = $clog2(MaxCredits + 1)
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            dec_i,
    input  wire logic            inc_i,
    output logic [CntW-1:0]      cnt_o,
    output logic                 ovf_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == CntW'(MaxCredits)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CntW'(MaxCredits);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/serial_link_axi_chan_packer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_link_axi_chan_packer
//  Purpose  : Round-robin arbitration over NumChan payload streams that have
//             both data and credit; the granted payload is cut into
//             FlitDataWidth-bit flits (LSB slice first) tagged with channel
//             id and a last flag.
//  Ports    : clk_i, rst_i   - clock, synchronous active-high reset
//             bus (slave)    - payload inputs and flit output stream
//             credit_ret_i   - per-channel one-cycle credit return
//             credit_cnt_o   - per-channel current credit count
//             err_credit_o   - sticky credit-overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module serial_link_axi_chan_packer
    import serial_link_chan_pkg::*;
#(
    parameter int unsigned NumChan              = 3,
    parameter int unsigned FlitDataWidth        = 16,
    parameter int unsigned ChanBits [NumChan]   = DEFAULT_CHAN_BITS,
    parameter int unsigned MaxChanBits          = 69,
    parameter int unsigned ChanCredits          = 4
) (
    input  wire logic                                          clk_i,
    input  wire logic                                          rst_i,
    serial_link_axi_chan_packer_if.slave                       bus,
    input  wire logic [NumChan-1:0]                            credit_ret_i,
    output logic [NumChan-1:0][$clog2(ChanCredits+1)-1:0]      credit_cnt_o,
    output logic                                               err_credit_o
);

    localparam int unsigned CHAN_ID_W = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned CRED_W    = $clog2(ChanCredits + 1);
    localparam int unsigned MAX_FLITS = num_flits(MaxChanBits, FlitDataWidth);
    localparam int unsigned SH_W      = MAX_FLITS * FlitDataWidth;
    localparam int unsigned FCNT_W    = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

    pack_state_e           state_q, state_d;
    logic [SH_W-1:0]       shreg_q, shreg_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic [CHAN_ID_W-1:0]  chan_q, chan_d;
    logic [CHAN_ID_W-1:0]  rr_q, rr_d;

    logic [NumChan-1:0]             w_eligible;
    logic [NumChan-1:0]             w_grant_oh;
    logic                           w_grant_any;
    logic [CHAN_ID_W-1:0]           w_grant_idx;
    logic [NumChan-1:0][SH_W-1:0]   w_payload;
    logic [NumChan-1:0][FCNT_W-1:0] w_last_idx;
    logic [NumChan-1:0]             w_cred_nz;
    logic [NumChan-1:0]             w_ovf;
    logic [NumChan-1:0][CRED_W-1:0] w_cnt;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        localparam int unsigned BITS = ChanBits[c];

        logic [SH_W-1:0] w_pay;

        // Bits above the channel width are forced to zero so the last
        // flit comes out zero-padded.
        always_comb begin
            w_pay = '0;
            for (int b = 0; b < int'(MaxChanBits); b++) begin
                if (b < int'(BITS)) begin
                    w_pay[b] = bus.in_data_i[c][b];
                end
            end
        end

        assign w_payload[c]  = w_pay;
        assign w_last_idx[c] = FCNT_W'(num_flits(BITS, FlitDataWidth) - 1);

        serial_link_credit_cnt #(
            .MaxCredits (ChanCredits),
            .CntW       (CRED_W)
        ) u_credit_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .dec_i (w_grant_oh[c]),
            .inc_i (credit_ret_i[c]),
            .cnt_o (w_cnt[c]),
            .ovf_o (w_ovf[c])
        );

        assign w_cred_nz[c]    = (w_cnt[c] != '0);
        assign credit_cnt_o[c] = w_cnt[c];
    end

    // Round-robin search: first eligible channel at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        w_eligible  = bus.in_valid_i & w_cred_nz;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < int'(NumChan); i++) begin
            idx = (int'(rr_q) + i) % int'(NumChan);
            if (!w_grant_any && w_eligible[idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = CHAN_ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        fcnt_d     = fcnt_q;
        chan_d     = chan_q;
        rr_d       = rr_q;
        w_grant_oh = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_grant_oh[w_grant_idx] = 1'b1;
                    shreg_d = w_payload[w_grant_idx];
                    fcnt_d  = w_last_idx[w_grant_idx];
                    chan_d  = w_grant_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_ready_i) begin
                    shreg_d = shreg_q >> FlitDataWidth;
                    if (fcnt_q == '0) begin
                        state_d = ST_IDLE;
                        rr_d    = CHAN_ID_W'((int'(chan_q) + 1) % int'(NumChan));
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            fcnt_q  <= '0;
            chan_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            fcnt_q  <= fcnt_d;
            chan_q  <= chan_d;
            rr_q    <= rr_d;
        end
    end

    // The accept is combinational; hide it while reset is being applied.
    assign bus.in_ready_o  = rst_i ? '0 : w_grant_oh;
    assign bus.out_valid_o = (state_q == ST_SEND);
    assign bus.out_data_o  = shreg_q[FlitDataWidth-1:0];
    assign bus.out_chan_o  = chan_q;
    assign bus.out_last_o  = (state_q == ST_SEND) && (fcnt_q == '0);
    assign err_credit_o    = |w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_axi_chan_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_link_axi_chan_packer
//  Purpose  : Self-checking bench for serial_link_axi_chan_packer with a
//             flit-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_link_axi_chan_packer;
    import serial_link_chan_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       ret;
    logic [2:0][2:0]  cred_cnt;
    logic             err;

    always #5 clk = ~clk;

    serial_link_axi_chan_packer_if #(
        .NumChan(3), .FlitDataWidth(16), .MaxChanBits(69)
    ) bus ();

    serial_link_axi_chan_packer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.slave),
        .credit_ret_i (ret),
        .credit_cnt_o (cred_cnt),
        .err_credit_o (err)
    );

    typedef struct {
        logic [15:0] d;
        int          ch;
        bit          last;
    } flit_t;

    localparam int CH_BITS [3] = '{69, 38, 63};

    flit_t       m_q[$];
    int          m_cred[3];
    int          m_rr;
    bit          m_err;
    logic [15:0] obs_log[$];
    chan_id_t    grant_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [68:0] rnd69();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[68:0];
    endfunction

    function automatic logic [2:0] safe_ret();
        logic [2:0] r;
        for (int c = 0; c < 3; c++) r[c] = (m_cred[c] < 4) && ($urandom_range(0, 1) == 1);
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int c = 0; c < 3; c++) m_cred[c] = 4;
        m_rr  = 0;
        m_err = 0;
    endtask

    // Called at a falling edge with inputs already driven: checks outputs,
    // advances the model across the next rising edge, returns at the
    // following falling edge.
    task automatic tick();
        int          g;
        bit          busy;
        logic [2:0]  exp_rdy;
        logic [79:0] p;
        int          nf;
        flit_t       f;
        #1;
        busy = (m_q.size() != 0);
        g    = -1;
        if (!rst && !busy) begin
            for (int i = 0; i < 3; i++) begin
                int c;
                c = (m_rr + i) % 3;
                if (g < 0 && bus.in_valid_i[c] && m_cred[c] > 0) g = c;
            end
        end
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        check("in_ready", 64'(bus.in_ready_o), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid_o), 64'(busy));
        if (busy) begin
            check("out_data", 64'(bus.out_data_o), 64'(m_q[0].d));
            check("out_chan", 64'(bus.out_chan_o), 64'(m_q[0].ch));
            check("out_last", 64'(bus.out_last_o), 64'(m_q[0].last));
        end else begin
            check("out_last_idle", 64'(bus.out_last_o), 64'd0);
        end
        for (int c = 0; c < 3; c++) check("credit_cnt", 64'(cred_cnt[c]), 64'(m_cred[c]));
        check("err_credit", 64'(err), 64'(m_err));

        if (bus.out_valid_o && bus.out_ready_i) obs_log.push_back(bus.out_data_o);
        for (int c = 0; c < 3; c++) if (bus.in_ready_o[c]) grant_log.push_back(chan_id_t'(c));

        if (rst) begin
            model_reset();
        end else begin
            if (busy && bus.out_ready_i) begin
                f = m_q.pop_front();
                if (f.last) m_rr = (f.ch + 1) % 3;
            end
            if (g >= 0) begin
                p  = 80'(bus.in_data_i[g]) & ((80'd1 << CH_BITS[g]) - 80'd1);
                nf = (CH_BITS[g] + 15) / 16;
                for (int k = 0; k < nf; k++) begin
                    f.d    = p[16*k +: 16];
                    f.ch   = g;
                    f.last = (k == nf - 1);
                    m_q.push_back(f);
                end
                m_cred[g]--;
            end
            for (int c = 0; c < 3; c++) begin
                if (ret[c]) begin
                    if (g == c)           m_cred[c]++;
                    else if (m_cred[c] == 4) m_err = 1;
                    else                  m_cred[c]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid_i = '0;
        ret            = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] aw_flits [5];
        aw_flits = '{16'hEF01, 16'hABCD, 16'h6789, 16'h2345, 16'h0001};

        rst             = 1'b1;
        ret             = '0;
        bus.in_valid_i  = '0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_out_data", 64'(bus.out_data_o), 64'd0);
        check("rst_out_chan", 64'(bus.out_chan_o), 64'd0);
        tick();

        // Single AW packet with known payload
        obs_log.delete();
        bus.out_ready_i  = 1'b1;
        bus.in_valid_i   = 3'b001;
        bus.in_data_i[0] = 69'h1_2345_6789_ABCD_EF01;
        tick();
        bus.in_valid_i = '0;
        repeat (6) tick();
        check("aw_flit_count", 64'(obs_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < obs_log.size(); k++)
            check("aw_flit", 64'(obs_log[k]), 64'(aw_flits[k]));
        check("aw_credit", 64'(cred_cnt[0]), 64'd3);

        // All channels valid, credits returned as they are consumed
        do_reset();
        grant_log.delete();
        bus.out_ready_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            bus.in_valid_i = 3'b111;
            for (int c = 0; c < 3; c++) bus.in_data_i[c] = rnd69();
            ret = safe_ret();
            tick();
        end
        check("rr_grant0", 64'(grant_log[0]), 64'd0);
        check("rr_grant1", 64'(grant_log[1]), 64'd1);
        check("rr_grant2", 64'(grant_log[2]), 64'd2);
        check("rr_grant3", 64'(grant_log[3]), 64'd0);

        // Random traffic with output back-pressure
        for (int t = 0; t < 250; t++) begin
            bus.in_valid_i  = 3'($urandom);
            for (int c = 0; c < 3; c++) bus.in_data_i[c] = rnd69();
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            ret = safe_ret();
            tick();
        end

        // W only, no credit return: four packets, then blocked
        do_reset();
        grant_log.delete();
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 3'b010;
        for (int t = 0; t < 24; t++) begin
            bus.in_data_i[1] = rnd69();
            tick();
        end
        check("w_packets_no_credit", 64'(grant_log.size()), 64'd4);
        ret = 3'b010;
        tick();
        ret = '0;
        repeat (6) tick();
        check("w_packets_after_return", 64'(grant_log.size()), 64'd5);

        // Credit overflow and grant+return in the same cycle
        do_reset();
        bus.in_valid_i = '0;
        ret = 3'b100;
        tick();
        ret = '0;
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_credit", 64'(cred_cnt[2]), 64'd4);
        for (int p = 0; p < 2; p++) begin
            bus.in_valid_i   = 3'b100;
            bus.in_data_i[2] = rnd69();
            tick();
            bus.in_valid_i = '0;
            repeat (4) tick();
        end
        check("ar_credit_two", 64'(cred_cnt[2]), 64'd2);
        bus.in_valid_i   = 3'b100;
        bus.in_data_i[2] = rnd69();
        ret = 3'b100;
        tick();
        ret = '0;
        bus.in_valid_i = '0;
        check("grant_ret_net0", 64'(cred_cnt[2]), 64'd2);
        check("err_sticky", 64'(err), 64'd1);
        repeat (4) tick();
        do_reset();
        check("err_cleared", 64'(err), 64'd0);

        // Reset on the second flit of an AW packet
        bus.out_ready_i  = 1'b1;
        bus.in_valid_i   = 3'b001;
        bus.in_data_i[0] = rnd69();
        tick();
        bus.in_valid_i = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid_i = 3'b111;
        #1;
        check("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_grant", 64'(bus.in_ready_o), 64'd1);
        for (int c = 0; c < 3; c++) check("midrst_credit", 64'(cred_cnt[c]), 64'd4);
        tick();
        bus.in_valid_i = '0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
